sccomp_uart_tx: RTL
===================

SCCOMP_UART_TX -- requirements
Module: sccomp_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4: transmit FIFO entries, power of two, at least 2.
REQ-003 SHALL provide parameter BASE_ADDR, default 32'hFFFF_FF00: MMIO base address.
REQ-004 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 clr  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 addr  in  32  CPU data-memory address (aluout).
REQ-007 wdata  in  32  CPU store data.
REQ-008 wmem  in  1  CPU store strobe; a store is accepted only when wmem=1 and addr hits a register.
REQ-009 rdata  out  32  status read data; combinational from addr.
REQ-010 txd  out  1  serial output, idle high.
REQ-011 busy  out  1  high while a frame is on txd or the FIFO is non-empty.

Function
REQ-012 Register map SHALL be: BASE+0 DATA (write-only); BASE+4 STATUS with bit0 busy, bit1 empty, bit2 full, bit3 overflow, bits31:4 zero.
REQ-013 Reading any address other than BASE+4 SHALL return rdata=0; reads SHALL have no side effects.
REQ-014 A store to DATA when the FIFO is not full SHALL push wdata[7:0]; wdata[31:8] SHALL be ignored.
REQ-015 A store to DATA when the FIFO is full SHALL drop the byte, leave FIFO contents unchanged, and set the sticky overflow bit.
REQ-016 Exception to REQ-015: if a pop occurs on the same edge as a store to a full FIFO, the store SHALL be accepted and overflow SHALL NOT be set.
REQ-017 Any store to STATUS SHALL clear overflow; a simultaneous overflow event SHALL win, leaving overflow=1.
REQ-018 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-019 IDLE: txd=1; when the FIFO is non-empty, the FSM SHALL pop the head into the shift register and enter START on that edge.
REQ-020 START: txd=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-021 DATA: txd SHALL carry shift-register bits LSB first, each for CLKS_PER_BIT cycles; after bit 7 the FSM SHALL enter STOP.
REQ-022 STOP: txd=1 for CLKS_PER_BIT cycles; then, if the FIFO is non-empty, the FSM SHALL pop and enter START directly with no idle cycle; otherwise it SHALL enter IDLE.
REQ-023 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-024 Latency: for a store accepted at edge k into an empty FIFO with FSM in IDLE, txd SHALL fall at edge k+1.
REQ-025 Bytes SHALL be transmitted in store order; FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-026 A store to DATA while a frame is in progress SHALL NOT disturb the current frame.
REQ-027 The baud counter SHALL be 16 bits wide and SHALL reset to 0 on every state transition.
REQ-028 busy SHALL equal (state != IDLE) OR (FIFO not empty), registered-state based with no extra delay.

Reset
REQ-029 While clr=1 at a rising edge: state=IDLE, txd=1, FIFO empty (empty=1, full=0), overflow=0, baud and bit counters=0, busy=0.
REQ-030 Assertion of clr mid-frame SHALL abort the frame; txd SHALL be 1 after that edge and queued bytes SHALL be discarded.
REQ-031 A store presented in a cycle where clr=1 SHALL be ignored.

Verification
REQ-032 Single byte (CLKS_PER_BIT=4): store 0x55 to BASE -> txd low at the next edge, then pattern 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop), 4 cycles each; busy=0 after 40 cycles.
REQ-033 Back-to-back: store 0xA5 then 0x3C on consecutive cycles -> two 40-cycle frames with no idle gap between them; data bits 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
REQ-034 Overflow: with FIFO_DEPTH=4, while frame 1 is active, store 5 further bytes -> the 5th is dropped and STATUS reads 0xD (overflow, full, busy); a store to BASE+4 then gives STATUS 0x5.
REQ-035 Full with simultaneous pop: FIFO full, store issued on the STOP->START pop edge -> byte accepted, overflow stays 0, all bytes transmitted in order.
REQ-036 Reset mid-frame: assert clr during DATA bit 3 -> txd=1 and STATUS=0x2 after that edge; after clr is released, no further frames unless new stores arrive.
REQ-037 Address decode: store to BASE+8 and a read of BASE+0 -> no push, rdata=0, overflow unchanged.

Source files
------------

// File: rtl/sccomp_uart_tx.sv
// sccomp_uart_tx: memory-mapped 8N1 UART transmitter with a small byte FIFO.
// DATA at BASE+0 queues a byte; STATUS at BASE+4 reports busy/empty/full/overflow.
module sccomp_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FF00
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        wmem,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        busy
);

  localparam int unsigned  PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [15:0]  BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [15:0]        baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic [7:0]         mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     count;
  logic               overflow;

  logic fifo_empty;
  logic fifo_full;
  logic baud_done;
  logic data_hit;
  logic stat_hit;
  logic pop;
  logic push_req;
  logic push;
  logic ovf_set;
  logic unused_wdata;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_CNT);
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign data_hit   = (addr == BASE_ADDR);
  assign stat_hit   = (addr == BASE_ADDR + 32'd4);

  // The head is consumed when leaving IDLE or at the last STOP cycle, so a
  // store to a full FIFO on that same edge still finds a free slot.
  assign pop      = !fifo_empty && ((state == IDLE) || (state == STOP && baud_done));
  assign push_req = wmem && data_hit && !clr;
  assign push     = push_req && (!fifo_full || pop);
  assign ovf_set  = push_req && fifo_full && !pop;

  assign unused_wdata = ^wdata[31:8];

  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   if (baud_done) state_nxt = DATA;
      DATA:    if (baud_done && bit_cnt == 3'd7) state_nxt = STOP;
      STOP:    if (baud_done) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    unique case (state)
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      default: txd = 1'b1;
    endcase
    busy  = (state != IDLE) || !fifo_empty;
    rdata = '0;
    if (stat_hit) rdata = {28'd0, overflow, fifo_full, fifo_empty, busy};
  end

  // Baud counter restarts on every state change and on each data-bit boundary.
  always_ff @(posedge clk) begin
    if (clr) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      if (state_nxt != state || state == IDLE || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + 16'd1;
      end

      if (pop) begin
        shreg <= mem[rd_ptr];
      end else if (state == DATA && baud_done) begin
        shreg <= {1'b0, shreg[7:1]};
      end

      if (state_nxt != state) begin
        bit_cnt <= '0;
      end else if (state == DATA && baud_done) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      unique case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase

      // A drop on the same edge as a STATUS store leaves the flag set.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (wmem && stat_hit) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
